// File: rtl/dsc_pkg.sv
// dsc_pkg: shared constants and FSM state type for the stochastic-to-binary
// converter (stoch2bin4) and its per-lane counter (stoch2bin_lane).
//   DSC_BITS  - binary width per lane, log2 of the conversion window
//   DSC_LANES - number of parallel bitstream lanes
package dsc_pkg;

    localparam int DSC_BITS  = 10;
    localparam int DSC_LANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } dsc_state_e;

endpackage

// File: rtl/stoch2bin_lane.sv
// stoch2bin_lane: saturating BITS-wide ones counter for one stochastic lane.
// Optional build macro: STOCH2BIN_SORT_CHECK_EN (exposes the next-count value
// so the top can compare lanes on the same edge the last sample lands).
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clear count to 0 (wins over en)
//   en        - take one sample this cycle
//   bit_in    - stochastic bit; count increments when en & bit_in
//   cnt       - current count
//   cnt_nxt   - value cnt will take on the next edge (sort-check builds only)
module stoch2bin_lane
    import dsc_pkg::*;
#(
    parameter int BITS = DSC_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic            bit_in,
`ifdef STOCH2BIN_SORT_CHECK_EN
    output logic [BITS-1:0] cnt_nxt,
`endif
    output logic [BITS-1:0] cnt
);

    logic [BITS-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && bit_in && (cnt_q != '1)) begin
            // Stop at all-ones so a full window of ones reads max, not 0.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
`ifdef STOCH2BIN_SORT_CHECK_EN
    assign cnt_nxt = cnt_d;
`endif

endmodule

// File: rtl/stoch2bin4.sv
// stoch2bin4: converts LANES deterministic-stochastic bitstreams into binary
// counts over a window of 2^BITS enabled samples.
// Optional build macro: STOCH2BIN_SORT_CHECK_EN -- when defined, sort_err
// flags a window whose lane counts are not non-increasing (lane0>=lane1>=...);
// when undefined, sort_err is tied low.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   en         - sample enable; low freezes an active window
//   start      - open a new window (from IDLE, or from HOLD on handshake)
//   sn_in      - one stochastic bit per lane per cycle, lane 0 = a
//   busy       - high while counting
//   out_valid  - result held and valid
//   out_ready  - consumer accepts result (only meaningful in HOLD)
//   bin_out    - lane i count at [i*BITS +: BITS], shown in every state
//   sort_err   - lane ordering violation for the held result
module stoch2bin4
    import dsc_pkg::*;
#(
    parameter int BITS  = DSC_BITS,
    parameter int LANES = DSC_LANES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [LANES-1:0]      sn_in,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*BITS-1:0] bin_out,
    output logic                  sort_err
);

    dsc_state_e                   state_d, state_q;
    logic [BITS-1:0]              win_d, win_q;
    logic                         clr;
    logic                         cnt_en;
    logic [LANES-1:0][BITS-1:0]   cnt;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        clr     = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                    win_d   = '0;
                    clr     = 1'b1;
                end
            end
            COUNT: begin
                if (en) begin
                    cnt_en = 1'b1;
                    win_d  = win_q + 1'b1;   // wraps to 0 at window end
                    if (win_q == '1) state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        // Back-to-back window: skip IDLE entirely.
                        state_d = COUNT;
                        win_d   = '0;
                        clr     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
        end
    end

`ifdef STOCH2BIN_SORT_CHECK_EN
    logic [LANES-1:0][BITS-1:0] cnt_nxt;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        stoch2bin_lane #(.BITS(BITS)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr),
            .en      (cnt_en),
            .bit_in  (sn_in[i]),
`ifdef STOCH2BIN_SORT_CHECK_EN
            .cnt_nxt (cnt_nxt[i]),
`endif
            .cnt     (cnt[i])
        );
    end

    assign busy      = (state_q == COUNT);
    assign out_valid = (state_q == HOLD);
    assign bin_out   = cnt;

`ifdef STOCH2BIN_SORT_CHECK_EN
    logic sort_upd;
    logic sort_d, sort_q;

    // Judge ordering on the edge the last sample lands, using the counts
    // the lanes are about to take, so the flag is ready with out_valid.
    assign sort_upd = (state_q == COUNT) && en && (win_q == '1);

    always_comb begin
        sort_d = sort_q;
        if (clr) sort_d = 1'b0;
        if (sort_upd) begin
            sort_d = 1'b0;
            for (int i = 0; i < LANES - 1; i++) begin
                if (cnt_nxt[i] < cnt_nxt[i+1]) sort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sort_q <= 1'b0;
        else     sort_q <= sort_d;
    end

    assign sort_err = sort_q;
`else
    assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_stoch2bin4.sv
// tb_stoch2bin4: table-driven self-checking bench for stoch2bin4, plus
// hand-written sequences for reset-mid-window and HOLD back-pressure.
module tb_stoch2bin4;

    localparam int BITS  = 10;
    localparam int LANES = 4;
`ifdef STOCH2BIN_SORT_CHECK_EN
    localparam bit SORT_ON = 1'b1;
`else
    localparam bit SORT_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  start;
    logic [LANES-1:0]      sn_in;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*BITS-1:0] bin_out;
    logic                  sort_err;

    int n_chk  = 0;
    int n_fail = 0;

    stoch2bin4 #(.BITS(BITS), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .sn_in     (sn_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .sort_err  (sort_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    v[4];      // comparator thresholds per lane
        bit    tog;       // en toggles 0/1 each cycle
        int    exp_cyc;   // cycle on which out_valid first seen
        int    exp[4];    // expected lane counts
        bit    unsorted;  // lanes violate a>=b>=c>=d
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enter at posedge+1. Opens a window and drives comparator streams
    // (lane bit = ramp < v) until out_valid or the cycle budget expires.
    task automatic run_window(input int v[4], input bit tog, output int cyc);
        int ramp;
        ramp  = 0;
        cyc   = 0;
        start = 1'b1;
        en    = 1'b1;
        sn_in = '0;
        while (1) begin
            tick();
            cyc++;
            if (out_valid || cyc > 3000) break;
            start = (cyc <= 5);   // start while counting must be ignored
            en    = tog ? (cyc % 2 == 0) : 1'b1;
            if (en) begin
                for (int i = 0; i < LANES; i++) sn_in[i] = (ramp < v[i]);
                ramp++;
            end else begin
                sn_in = '1;       // must be ignored while en=0
            end
        end
        start = 1'b0;
        en    = 1'b0;
        sn_in = '0;
    endtask

    vec_t vecs[6];
    int   cyc;
    logic [LANES*BITS-1:0] snap;
    int   bad;

    initial begin
        vecs[0] = '{"ramp",     '{700, 500, 300, 100},   1'b0, 1025, '{700, 500, 300, 100},   1'b0};
        vecs[1] = '{"ones",     '{1024, 1024, 1024, 1024}, 1'b0, 1025, '{1023, 1023, 1023, 1023}, 1'b0};
        vecs[2] = '{"zeros",    '{0, 0, 0, 0},           1'b0, 1025, '{0, 0, 0, 0},           1'b0};
        vecs[3] = '{"ramp_tog", '{700, 500, 300, 100},   1'b1, 2049, '{700, 500, 300, 100},   1'b0};
        vecs[4] = '{"unsorted", '{100, 900, 500, 0},     1'b0, 1025, '{100, 900, 500, 0},     1'b1};
        vecs[5] = '{"edge",     '{1023, 512, 1, 0},      1'b0, 1025, '{1023, 512, 1, 0},      1'b0};

        rst = 1'b1; en = 1'b0; start = 1'b0; sn_in = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_busy",      busy,      0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bin_out",   bin_out,   0);
        chk("rst_sort_err",  sort_err,  0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            run_window(vecs[k].v, vecs[k].tog, cyc);
            chk({vecs[k].name, "_latency"}, cyc, vecs[k].exp_cyc);
            chk({vecs[k].name, "_busy"}, busy, 0);
            for (int i = 0; i < LANES; i++)
                chk({vecs[k].name, "_lane", $sformatf("%0d", i)}, bin_out[i*BITS +: BITS], vecs[k].exp[i]);
            chk({vecs[k].name, "_sort_err"}, sort_err, vecs[k].unsorted & SORT_ON);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({vecs[k].name, "_hs_idle"}, {busy, out_valid}, 2'b00);
            tick();
        end

        // Reset in the middle of a window discards it.
        start = 1'b1; en = 1'b1; sn_in = '1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 300; c++) tick();
        chk("mid_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy",      busy,      0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_bin_out",   bin_out,   0);
        tick(); tick();
        rst = 1'b0;
        out_ready = 1'b1;   // no effect outside HOLD
        bad = 0;
        for (int c = 0; c < 1100; c++) begin
            tick();
            if (out_valid || busy) bad++;
        end
        chk("post_rst_no_valid", bad, 0);
        out_ready = 1'b0; en = 1'b0; sn_in = '0;
        tick();

        // Back-pressure in HOLD with start pulses, then handshake+restart.
        run_window(vecs[0].v, 1'b0, cyc);
        chk("stall_latency", cyc, 1025);
        snap = bin_out;
        bad  = 0;
        for (int c = 0; c < 50; c++) begin
            start = (c == 10 || c == 30);
            en    = 1'b1;
            sn_in = '1;
            tick();
            if (!out_valid || busy || bin_out !== snap || sort_err !== 1'b0) bad++;
        end
        chk("stall_stable", bad, 0);
        chk("stall_lane0", bin_out[0 +: BITS], 700);
        start = 1'b1; out_ready = 1'b1; sn_in = '0;
        tick();
        start = 1'b0; out_ready = 1'b0;
        chk("restart_busy",      busy,      1);
        chk("restart_out_valid", out_valid, 0);
        chk("restart_bin_out",   bin_out,   0);
        sn_in = 4'b0001;
        tick();
        chk("restart_lane0_counts", bin_out[0 +: BITS], 1);
        en = 1'b0; sn_in = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
